fsm1_resp: RTL

Wait-state responder for the fsm1 read handshake (`go`/`ws` in, `rd`/`ds` out). Sits on the far side of any fsm1 master: it watches `rd`/`ds`, predicts the master state, and drives `ws` in the master's DLY cycle so each transaction gets a programmed number of extra READ/DLY loops. It also counts completed transactions and, optionally, flags protocol violations. The bench uses it to close the loop around the fsm1 variants instead of driving random `ws`.

---
 rtl/fsm1_resp.sv | 112 +++++++++++
 1 files changed

// File: rtl/fsm1_resp.sv
// Wait-state responder for the fsm1 read handshake: tracks the master state from rd/ds
// and answers ws. Optional violation flag built when FSM1_RESP_CHECK_EN is defined.
module fsm1_resp #(
  parameter int CNT_W = 4,
  parameter int TXN_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             rd,
  input  logic             ds,
  input  logic [CNT_W-1:0] wait_cnt,
  output logic             ws,
  output logic             busy,
  output logic             done,
  output logic [CNT_W:0]   beats,
  output logic [TXN_W-1:0] txn_cnt,
  output logic             err
);

  typedef enum logic [1:0] {P_IDLE, P_DLY, P_READ, P_DONE} p_state_t;

  p_state_t         state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [CNT_W:0]   bcnt, bcnt_nx;
  logic             ws_q, ws_q_nx;
  logic             viol, fin;

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    bcnt_nx  = bcnt;
    ws_q_nx  = ws_q;
    viol     = 1'b0;
    fin      = 1'b0;
    case (state)
      P_IDLE: begin
        if (ds) viol = 1'b1;
        else if (rd) begin
          rem_nx   = wait_cnt;
          bcnt_nx  = (CNT_W+1)'(1);
          ws_q_nx  = (wait_cnt != '0);
          state_nx = P_DLY;
        end
      end
      P_DLY: begin
        if (!rd) viol = 1'b1;
        else if (ws_q) begin
          rem_nx   = rem - 1'b1;
          state_nx = P_READ;
        end else state_nx = P_DONE;
      end
      P_READ: begin
        if (!rd) viol = 1'b1;
        else begin
          bcnt_nx  = bcnt + 1'b1;
          ws_q_nx  = (rem != '0);
          state_nx = P_DLY;
        end
      end
      P_DONE: begin
        if (!ds || rd) viol = 1'b1;
        else begin
          fin      = 1'b1;
          state_nx = P_IDLE;
        end
      end
      default: state_nx = P_IDLE;
    endcase
    // Any mismatch drops the prediction; the next rd rise starts a fresh transaction.
    if (viol) begin
      state_nx = P_IDLE;
      ws_q_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= P_IDLE;
      rem     <= '0;
      bcnt    <= '0;
      ws_q    <= 1'b0;
      beats   <= '0;
      txn_cnt <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      bcnt  <= bcnt_nx;
      ws_q  <= ws_q_nx;
      if (fin) begin
        beats   <= bcnt;
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

`ifdef FSM1_RESP_CHECK_EN
  logic err_q;
  always_ff @(posedge CLK) begin
    if (!RST_N)    err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Outputs decode registered state only; done marks the predicted master DONE cycle.
  assign ws   = ws_q & (state == P_DLY);
  assign busy = (state != P_IDLE);
  assign done = (state == P_DONE);

endmodule
